// File: rtl/unified_byte_memory_pkg.sv
// ============================================================================
// memory_pkg : shared types for the unified byte-addressable memory
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package memory_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/unified_byte_memory_if.sv
// ============================================================================
// unified_byte_memory_if : request/response bus of the unified memory
// Rev 1.0                : initial release
// ============================================================================
`default_nettype none

interface unified_byte_memory_if;
  logic        i_reqValid;
  logic        o_reqReady;
  logic [31:0] i_addr;
  logic        i_writeEnable;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_writeData;
  logic        o_rspValid;
  logic        i_rspReady;
  logic [31:0] o_rspData;
  logic        o_rspError;

  modport slave (
    input  i_reqValid, i_addr, i_writeEnable, i_size, i_unsigned, i_writeData, i_rspReady,
    output o_reqReady, o_rspValid, o_rspData, o_rspError
  );

  modport master (
    output i_reqValid, i_addr, i_writeEnable, i_size, i_unsigned, i_writeData, i_rspReady,
    input  o_reqReady, o_rspValid, o_rspData, o_rspError
  );
endinterface

`default_nettype wire

// File: rtl/unified_byte_memory_lane_align.sv
// ============================================================================
// memory_lane_align : byte enables, store lane replication, load extraction
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module memory_lane_align
  import memory_pkg::*;
(
  input  mem_size_t   i_st_size,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_data,
  input  mem_size_t   i_ld_size,
  input  logic [1:0]  i_ld_lane,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_data,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Replicating the store data puts it on every lane; the byte enables pick the target.
  always_comb begin
    o_be      = 4'b0000;
    o_st_data = 32'h0;
    case (i_st_size)
      MEM_BYTE: begin
        o_be      = 4'b0001 << i_st_lane;
        o_st_data = {4{i_st_data[7:0]}};
      end
      MEM_HALF: begin
        o_be      = i_st_lane[1] ? 4'b1100 : 4'b0011;
        o_st_data = {2{i_st_data[15:0]}};
      end
      MEM_WORD: begin
        o_be      = 4'b1111;
        o_st_data = i_st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte    = i_ld_word[{i_ld_lane, 3'b000} +: 8];
    w_half    = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    o_ld_data = 32'h0;
    case (i_ld_size)
      MEM_BYTE: o_ld_data = i_ld_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      MEM_HALF: o_ld_data = i_ld_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      MEM_WORD: o_ld_data = i_ld_word;
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/unified_byte_memory.sv
// ============================================================================
// unified_byte_memory : shared instruction/data memory, byte/half/word access
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module unified_byte_memory
  import memory_pkg::*;
#(
  parameter int    DEPTH_WORDS  = 64,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  unified_byte_memory_if.slave  bus
);

  localparam int c_AW = $clog2(DEPTH_WORDS);

  logic [31:0]     r_mem [DEPTH_WORDS];
  mem_state_t      r_state, w_next;
  logic            w_req_ready, w_accept, w_err;
  mem_size_t       w_size;
  logic [c_AW-1:0] w_idx;
  logic            r_err, r_write, r_unsigned;
  mem_size_t       r_size;
  logic [1:0]      r_lane;
  logic [31:0]     r_rdata, w_rword, w_st_data, w_ld_data;
  logic [3:0]      w_be;

  assign w_size   = mem_size_t'(bus.i_size);
  assign w_idx    = bus.i_addr[c_AW+1:2];
  assign w_accept = bus.i_reqValid && w_req_ready;
  assign w_err    = (w_size == MEM_ILLEGAL)
                  || (w_size == MEM_HALF && bus.i_addr[0])
                  || (w_size == MEM_WORD && (bus.i_addr[1:0] != 2'b00))
                  || (bus.i_addr[31:c_AW+2] != '0);

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.i_reqValid) w_next = (READ_LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: w_next = RESP;
      RESP: begin
        w_req_ready = bus.i_rspReady;
        if (bus.i_rspReady)
          w_next = !bus.i_reqValid ? IDLE : ((READ_LATENCY == 1) ? RESP : WAIT);
      end
      default: w_next = IDLE;
    endcase
    // Nothing is accepted while reset is held.
    if (!i_arst_n) w_req_ready = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state    <= IDLE;
      r_err      <= 1'b0;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= MEM_BYTE;
      r_lane     <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_err      <= w_err;
        r_write    <= bus.i_writeEnable;
        r_unsigned <= bus.i_unsigned;
        r_size     <= w_size;
        r_lane     <= bus.i_addr[1:0];
      end
    end
  end

  // Array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (bus.i_writeEnable && !w_err) begin
        for (int k = 0; k < 4; k++)
          if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_st_data[8*k +: 8];
      end
      r_rdata <= r_mem[w_idx];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [31:0] r_rdata2;
      always_ff @(posedge i_clk) begin
        if (r_state == WAIT) r_rdata2 <= r_rdata;
      end
      assign w_rword = r_rdata2;
    end else begin : g_lat1
      assign w_rword = r_rdata;
    end
  endgenerate

  memory_lane_align u_align (
    .i_st_size     (w_size),
    .i_st_lane     (bus.i_addr[1:0]),
    .i_st_data     (bus.i_writeData),
    .i_ld_size     (r_size),
    .i_ld_lane     (r_lane),
    .i_ld_unsigned (r_unsigned),
    .i_ld_word     (w_rword),
    .o_be          (w_be),
    .o_st_data     (w_st_data),
    .o_ld_data     (w_ld_data)
  );

  assign bus.o_reqReady = w_req_ready;
  assign bus.o_rspValid = (r_state == RESP);
  assign bus.o_rspError = (r_state == RESP) && r_err;
  assign bus.o_rspData  = ((r_state == RESP) && !r_err && !r_write) ? w_ld_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_unified_byte_memory.sv
// ============================================================================
// tb_unified_byte_memory : directed vectors for the unified byte memory
// Rev 1.0                : initial release
// ============================================================================
`default_nettype none

module tb_unified_byte_memory;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  unified_byte_memory_if bus ();
  unified_byte_memory_if bus2 ();

  unified_byte_memory #(.DEPTH_WORDS(64), .READ_LATENCY(1), .INIT_FILE("")) dut (
    .i_clk (clk), .i_arst_n (arst_n), .bus (bus.slave)
  );
  unified_byte_memory #(.DEPTH_WORDS(64), .READ_LATENCY(2), .INIT_FILE("")) dut2 (
    .i_clk (clk), .i_arst_n (arst_n), .bus (bus2.slave)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected response", name);
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    vec_t v;
    v = '{we: we, sz: sz, uns: uns, addr: addr, wd: wd, exp_d: exp_d, exp_e: exp_e};
    vecs.push_back(v);
  endtask

  // One complete transaction on the latency-1 instance with i_rspReady held high.
  task automatic xact(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    bus.i_reqValid = 1'b1; bus.i_writeEnable = v.we; bus.i_size = v.sz;
    bus.i_unsigned = v.uns; bus.i_addr = v.addr; bus.i_writeData = v.wd;
    cyc = 0;
    while (!bus.o_reqReady && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk);
    @(negedge clk);
    bus.i_reqValid = 1'b0;
    cyc = 0;
    while (!bus.o_rspValid && cyc < 20) begin @(negedge clk); cyc++; end
    if (!bus.o_rspValid) timeout($sformatf("vec%0d_rsp", idx));
    else begin
      chk($sformatf("vec%0d_data", idx), bus.o_rspData, v.exp_d);
      chk($sformatf("vec%0d_err", idx), {31'h0, bus.o_rspError}, {31'h0, v.exp_e});
    end
  endtask

  task automatic l2_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d, input string name);
    @(negedge clk);
    bus2.i_reqValid = 1'b1; bus2.i_writeEnable = we; bus2.i_size = sz;
    bus2.i_unsigned = 1'b0; bus2.i_addr = addr; bus2.i_writeData = wd;
    chk({name, "_ready"}, {31'h0, bus2.o_reqReady}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus2.i_reqValid = 1'b0;
    chk({name, "_wait"}, {31'h0, bus2.o_rspValid}, 32'h0);
    @(negedge clk);
    chk({name, "_valid"}, {31'h0, bus2.o_rspValid}, 32'h1);
    chk({name, "_data"}, bus2.o_rspData, exp_d);
  endtask

  logic [31:0] b2b_exp [4];

  initial begin
    bus.i_reqValid = 0; bus.i_addr = 0; bus.i_writeEnable = 0; bus.i_size = 0;
    bus.i_unsigned = 0; bus.i_writeData = 0; bus.i_rspReady = 1;
    bus2.i_reqValid = 0; bus2.i_addr = 0; bus2.i_writeEnable = 0; bus2.i_size = 0;
    bus2.i_unsigned = 0; bus2.i_writeData = 0; bus2.i_rspReady = 1;

    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_reqReady", {31'h0, bus.o_reqReady}, 32'h1);
    chk("rst_rspValid", {31'h0, bus.o_rspValid}, 32'h0);
    chk("rst_rspData",  bus.o_rspData, 32'h0);
    chk("rst_rspError", {31'h0, bus.o_rspError}, 32'h0);

    add(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 2'b00, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0);
    add(0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 0);
    add(0, 2'b00, 0, 32'h12,  32'h0,        32'hFFFFFFAD, 0);
    add(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
    add(0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 0);
    add(1, 2'b10, 0, 32'h20,  32'hAAAAAAAA, 32'h0,        0);
    add(1, 2'b01, 0, 32'h22,  32'hFFFF1234, 32'h0,        0);
    add(0, 2'b10, 0, 32'h20,  32'h0,        32'h1234AAAA, 0);
    add(0, 2'b01, 0, 32'h20,  32'h0,        32'hFFFFAAAA, 0);
    add(0, 2'b01, 1, 32'h22,  32'h0,        32'h00001234, 0);
    add(0, 2'b10, 0, 32'h06,  32'h0,        32'h0,        1);
    add(1, 2'b10, 0, 32'h00,  32'h01020304, 32'h0,        0);
    add(1, 2'b00, 0, 32'h100, 32'h55,       32'h0,        1);
    add(0, 2'b10, 0, 32'h00,  32'h0,        32'h01020304, 0);
    add(0, 2'b11, 0, 32'h00,  32'h0,        32'h0,        1);
    add(0, 2'b01, 0, 32'h21,  32'h0,        32'h0,        1);
    add(1, 2'b10, 0, 32'h30,  32'h0,        32'h0,        0);
    add(1, 2'b00, 0, 32'h31,  32'h80,       32'h0,        0);
    add(1, 2'b00, 0, 32'h32,  32'hFFFFFFAB, 32'h0,        0);
    add(0, 2'b10, 0, 32'h30,  32'h0,        32'h00AB8000, 0);
    add(0, 2'b01, 0, 32'h30,  32'h0,        32'hFFFF8000, 0);
    add(1, 2'b01, 0, 32'h32,  32'h0000BEEF, 32'h0,        0);
    add(0, 2'b10, 0, 32'h30,  32'h0,        32'hBEEF8000, 0);

    for (int i = 0; i < vecs.size(); i++) xact(vecs[i], i);

    // Back-to-back byte loads: one accept and one response per cycle, in order.
    b2b_exp[0] = 32'hEF; b2b_exp[1] = 32'hBE; b2b_exp[2] = 32'hAD; b2b_exp[3] = 32'hDE;
    @(negedge clk);
    bus.i_reqValid = 1; bus.i_writeEnable = 0; bus.i_size = 2'b00; bus.i_unsigned = 1;
    bus.i_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", k), {31'h0, bus.o_rspValid}, 32'h1);
      chk($sformatf("b2b%0d_data", k), bus.o_rspData, b2b_exp[k]);
      if (k < 3) bus.i_addr = 32'h11 + k;
      else bus.i_reqValid = 0;
    end
    @(negedge clk);
    chk("b2b_drain", {31'h0, bus.o_rspValid}, 32'h0);

    // Backpressure: response held stable, no second request accepted.
    bus.i_rspReady = 0;
    bus.i_reqValid = 1; bus.i_size = 2'b10; bus.i_unsigned = 0; bus.i_addr = 32'h20;
    @(negedge clk);
    bus.i_addr = 32'h10;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {31'h0, bus.o_rspValid}, 32'h1);
      chk($sformatf("bp%0d_data", k), bus.o_rspData, 32'h1234AAAA);
      chk($sformatf("bp%0d_ready", k), {31'h0, bus.o_reqReady}, 32'h0);
      @(negedge clk);
    end
    bus.i_reqValid = 0; bus.i_rspReady = 1;
    @(negedge clk);
    chk("bp_release", {31'h0, bus.o_rspValid}, 32'h0);

    // Reset while a response is pending.
    bus.i_rspReady = 0;
    bus.i_reqValid = 1; bus.i_size = 2'b10; bus.i_addr = 32'h20;
    @(negedge clk);
    bus.i_reqValid = 0;
    chk("rr_pending", {31'h0, bus.o_rspValid}, 32'h1);
    #2 arst_n = 1'b0;
    #1;
    chk("rr_valid", {31'h0, bus.o_rspValid}, 32'h0);
    chk("rr_data", bus.o_rspData, 32'h0);
    chk("rr_error", {31'h0, bus.o_rspError}, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    bus.i_rspReady = 1;
    @(negedge clk);
    chk("rr_ready", {31'h0, bus.o_reqReady}, 32'h1);
    chk("rr_nostale", {31'h0, bus.o_rspValid}, 32'h0);
    xact('{we: 0, sz: 2'b10, uns: 0, addr: 32'h20, wd: 0, exp_d: 32'h1234AAAA, exp_e: 0}, 99);

    l2_req(1, 2'b10, 32'h08, 32'h11223344, 32'h0, "l2_st");
    l2_req(0, 2'b10, 32'h08, 32'h0, 32'h11223344, "l2_ldw");
    l2_req(0, 2'b00, 32'h09, 32'h0, 32'h00000033, "l2_ldb");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
